// File: rtl/mips_prog_loader.sv
// Byte-stream program loader: receives a length-prefixed frame of big-endian words,
// writes them to instruction memory, then releases the CPU. Macro PROG_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module mips_prog_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              error
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_DONE, S_ERROR
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CKSUM
`endif
    } state_t;

    // Word count is 16 bits but may equal 2^ADDR_W, so counters carry one extra bit.
    localparam logic [16:0] MAX_N = 17'(1 << ADDR_W);

    state_t              state_q, state_d, fin_st;
    logic [7:0]          lenhi_q, lenhi_d;
    logic [15:0]         len_q, len_d;
    logic [16:0]         cnt_q, cnt_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [23:0]         sh_q, sh_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [15:0]         nlen;
    logic                acc;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    assign fin_st   = S_CKSUM;
    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_WORD)   || (state_q == S_CKSUM);
`else
    assign fin_st   = S_DONE;
    assign in_ready = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_WORD);
`endif

    assign acc       = in_valid && in_ready;
    assign nlen      = {lenhi_q, in_data};
    assign mem_we    = (state_q == S_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_run   = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);
    assign busy      = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lenhi_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lenhi_q <= lenhi_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        lenhi_d = lenhi_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        if (acc && state_q != S_CKSUM) csum_d = csum_q ^ in_data;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    cnt_d   = '0;
                    bcnt_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (acc) begin
                    lenhi_d = in_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (acc) begin
                    len_d  = nlen;
                    bcnt_d = '0;
                    if (nlen == 16'd0)             state_d = fin_st;
                    else if ({1'b0, nlen} > MAX_N) state_d = S_ERROR;
                    else                           state_d = S_WORD;
                end
            end
            S_WORD: begin
                if (acc) begin
                    sh_d   = {sh_q[15:0], in_data};
                    bcnt_d = 2'(bcnt_q + 2'd1);
                    if (bcnt_q == 2'd3) begin
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = {sh_q, in_data};
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                cnt_d   = cnt_q + 17'd1;
                state_d = (cnt_d < {1'b0, len_q}) ? S_WORD : fin_st;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CKSUM: begin
                if (acc) state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: doc/mips_prog_loader.md
MIPS_PROG_LOADER -- requirements
Module: mips_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, instruction-memory word-address width (depth 2^ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32, instruction word width; fixed at 32.
REQ-003 SHALL have port clk1 in 1, the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port rst in 1, an asynchronous active-high reset.
REQ-005 SHALL have port start in 1, a one-cycle pulse that begins a load session.
REQ-006 SHALL have port in_data in 8, the byte stream from the host.
REQ-007 SHALL have port in_valid in 1, asserted while in_data holds a valid byte.
REQ-008 SHALL have port in_ready out 1; a byte transfers on any clk1 edge where in_valid and in_ready are both 1.
REQ-009 SHALL have port mem_we out 1, the instruction-memory write strobe.
REQ-010 SHALL have port mem_addr out ADDR_W, the word address.
REQ-011 SHALL have port mem_wdata out 32, the instruction word.
REQ-012 SHALL have port cpu_run out 1; the processor is released while it is 1.
REQ-013 SHALL have port busy out 1, high in every state except IDLE, DONE and ERROR.
REQ-014 SHALL have port error out 1, the sticky load-failure flag.

Function
REQ-015 SHALL implement the FSM states IDLE, LEN_HI, LEN_LO, WORD, WRITE, CKSUM, DONE and ERROR.
REQ-016 SHALL, on start in IDLE, DONE or ERROR, enter LEN_HI and clear cpu_run, error, the word counter and the checksum accumulator; start is ignored in every other state.
REQ-017 SHALL take the frame as: 16-bit word count N, MSB first; then N words of 4 bytes each, big-endian; then the optional checksum byte (REQ-027).
REQ-018 SHALL drive in_ready to 1 only in LEN_HI, LEN_LO, WORD and CKSUM.
REQ-019 SHALL make in_valid gaps insert wait cycles without losing or duplicating bytes.
REQ-020 SHALL, on the 4th byte accepted in WORD, go to WRITE; in WRITE, mem_we=1 for exactly one cycle, mem_addr=word index (0-based, ascending) and mem_wdata=assembled word, with in_ready=0.
REQ-021 SHALL, after WRITE, increment the index and return to WORD if index<N; otherwise it goes to CKSUM (checksum macro defined) or DONE (macro undefined).
REQ-022 SHALL, when N=0, go from LEN_LO directly to CKSUM or DONE with no write.
REQ-023 SHALL, when N>2^ADDR_W, go from LEN_LO to ERROR with no write.
REQ-024 SHALL hold cpu_run=1 in DONE until rst or start; in ERROR, error=1 and cpu_run=0.
REQ-025 SHALL hold mem_addr and mem_wdata at their last values when mem_we=0.

Reset
REQ-026 SHALL, on rst (async, any state, including mid-word), go to IDLE with in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, error=0 and the partial word discarded.

Configuration
REQ-027 SHALL support the macro PROG_LOADER_CHECKSUM_EN: when defined, the frame ends with one byte equal to the XOR of all preceding frame bytes (count bytes included); a match goes to DONE and a mismatch goes to ERROR. Undefined: no checksum byte and no CKSUM state; the last WRITE goes directly to DONE.

Verification
REQ-028 SHALL cover this scenario (checksum on): bytes 00 02 00 01 50 00 24 01 00 C8 BE -> writes addr0=0x00015000 and addr1=0x240100C8, then cpu_run=1 and error=0.
REQ-029 SHALL cover this scenario: the same frame with last byte BF -> both writes occur, then error=1 and cpu_run=0.
REQ-030 SHALL cover this scenario: bytes 00 00 00 -> no mem_we, DONE, cpu_run=1; with the macro undefined, bytes 00 00 -> DONE.
REQ-031 SHALL cover this scenario: ADDR_W=10, bytes 04 01 -> ERROR with no mem_we and in_ready=0.
REQ-032 SHALL cover this scenario: rst after 2 bytes of a word, then start and a valid 1-word frame -> a single write to addr0 holding only the new word.
REQ-033 SHALL cover this scenario: in_valid toggling 1-of-3 cycles across the 2-word frame -> writes and cpu_run identical to REQ-028.
